// File: rtl/interrupt_controller.sv
// Two-source, edge-triggered interrupt controller with a byte-wide
// return-address stack. Entry pushes the PC (low byte, then high byte),
// then loads the vector. RETI pops the high byte, then the low byte, and
// reloads the PC. Clock is "clock"; "reset" is synchronous and active low.
// The interrupt-in-progress output is named "intr" because "int" is a
// reserved word in SystemVerilog.
module interrupt_controller #(
  parameter int          STACK_DEPTH = 16,
  parameter logic [15:0] VEC0        = 16'h0003,
  parameter logic [15:0] VEC1        = 16'h0013
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [1:0]                   irq_req,
  input  logic                         int_en,
  input  logic [15:0]                  pc_in,
  input  logic                         pop_1_stack,
  input  logic                         pop_2_stack,
  output logic                         intr,
  output logic                         pc_load,
  output logic [15:0]                  pc_out,
  output logic [$clog2(STACK_DEPTH):0] sp_out,
  output logic                         stack_err
);

  localparam int AW  = $clog2(STACK_DEPTH);
  localparam int SPW = AW + 1;
  localparam logic [SPW-1:0] SP_LIMIT = SPW'(STACK_DEPTH - 2);

  typedef enum logic [2:0] {
    IDLE, PUSH_LO, PUSH_HI, VECTOR, IN_SERVICE, RETURN
  } state_t;

  state_t           state_reg, state_next;
  logic [SPW-1:0]   sp_reg, sp_next, sp_dec;
  logic [1:0]       pending_reg, pending_next;
  logic [1:0]       irq_q_reg, rise;
  logic [15:0]      pc_save_reg, pc_save_next;
  logic             src_reg, src_next;
  logic [7:0]       ret_hi_reg, ret_lo_reg;
  logic             ret_hi_load, ret_lo_load;
  logic             err_reg, err_next;
  logic             int_reg, int_next;
  logic             pushing;
  logic [7:0]       push_data;
  logic [AW-1:0]    wr_addr, rd_addr;

  // Return-address stack; contents deliberately survive reset.
  logic [7:0]       stack_mem [STACK_DEPTH];

  // Per-line rising-edge detection against the previous sample.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_edge
      assign rise[gi] = irq_req[gi] & ~irq_q_reg[gi];
    end
  endgenerate

  assign pushing   = (state_reg == PUSH_LO) || (state_reg == PUSH_HI);
  assign push_data = (state_reg == PUSH_LO) ? pc_save_reg[7:0] : pc_save_reg[15:8];
  assign sp_dec    = sp_reg - SPW'(1);
  assign wr_addr   = sp_reg[AW-1:0];
  assign rd_addr   = sp_reg[AW-1:0] - AW'(1);

  // Next-state, stack-pointer, pending and error logic.
  always_comb begin
    state_next   = state_reg;
    sp_next      = sp_reg;
    pending_next = pending_reg | rise;
    pc_save_next = pc_save_reg;
    src_next     = src_reg;
    err_next     = err_reg;
    ret_hi_load  = 1'b0;
    ret_lo_load  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (int_en && (pending_reg != 2'b00)) begin
          if (sp_reg <= SP_LIMIT) begin
            state_next   = PUSH_LO;
            pc_save_next = pc_in;
            // Line 0 wins; a fresh edge on the chosen line re-arms it.
            if (pending_reg[0]) begin
              src_next        = 1'b0;
              pending_next[0] = rise[0];
            end else begin
              src_next        = 1'b1;
              pending_next[1] = rise[1];
            end
          end else begin
            // No room for two more bytes: refuse entry, keep requests.
            err_next = 1'b1;
          end
        end
      end
      PUSH_LO: begin
        sp_next    = sp_reg + SPW'(1);
        state_next = PUSH_HI;
      end
      PUSH_HI: begin
        sp_next    = sp_reg + SPW'(1);
        state_next = VECTOR;
      end
      VECTOR:     state_next = IN_SERVICE;
      RETURN:     state_next = IDLE;
      default:    state_next = state_reg;
    endcase

    // Pops act in every state except while the stack is being written.
    // pop_2 takes precedence when both are raised together.
    if (!pushing && (pop_1_stack || pop_2_stack)) begin
      if (sp_reg == '0) begin
        err_next = 1'b1;
      end else begin
        sp_next = sp_dec;
        if (pop_2_stack) begin
          ret_lo_load = 1'b1;
          if (state_reg == IN_SERVICE) begin
            state_next = RETURN;
          end
        end else begin
          ret_hi_load = 1'b1;
        end
      end
    end

    int_next = (state_next == PUSH_LO) || (state_next == PUSH_HI) ||
               (state_next == VECTOR);
  end

  // Control and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= IDLE;
      sp_reg      <= '0;
      pending_reg <= '0;
      irq_q_reg   <= '0;
      pc_save_reg <= '0;
      src_reg     <= 1'b0;
      ret_hi_reg  <= '0;
      ret_lo_reg  <= '0;
      err_reg     <= 1'b0;
      int_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sp_reg      <= sp_next;
      pending_reg <= pending_next;
      irq_q_reg   <= irq_req;
      pc_save_reg <= pc_save_next;
      src_reg     <= src_next;
      err_reg     <= err_next;
      int_reg     <= int_next;
      if (ret_hi_load) ret_hi_reg <= stack_mem[rd_addr];
      if (ret_lo_load) ret_lo_reg <= stack_mem[rd_addr];
    end
  end

  // Stack write port; suppressed while reset is asserted.
  always_ff @(posedge clock) begin
    if (reset && pushing) begin
      stack_mem[wr_addr] <= push_data;
    end
  end

  // PC load strobe and address decoded from the current state.
  always_comb begin
    pc_load = 1'b0;
    pc_out  = 16'h0000;
    if (state_reg == VECTOR) begin
      pc_load = 1'b1;
      pc_out  = src_reg ? VEC1 : VEC0;
    end else if (state_reg == RETURN) begin
      pc_load = 1'b1;
      pc_out  = {ret_hi_reg, ret_lo_reg};
    end
  end

  assign intr      = int_reg;
  assign sp_out    = sp_reg;
  assign stack_err = err_reg;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared cycle by cycle against a phase-based behavioural model.
module tb_interrupt_controller;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  irq_req = 2'b00;
  logic        int_en = 1'b0;
  logic [15:0] pc_in = 16'h0000;
  logic        pop_1_stack = 1'b0;
  logic        pop_2_stack = 1'b0;
  logic        intr, pc_load, stack_err;
  logic [15:0] pc_out;
  logic [2:0]  sp_out;

  interrupt_controller #(.STACK_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .irq_req(irq_req), .int_en(int_en),
    .pc_in(pc_in), .pop_1_stack(pop_1_stack), .pop_2_stack(pop_2_stack),
    .intr(intr), .pc_load(pc_load), .pc_out(pc_out), .sp_out(sp_out),
    .stack_err(stack_err)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Model state: phase 0 idle, 1..3 the three entry cycles, 4 in service,
  // 5 returning. The stack is a plain byte array indexed by the byte count.
  logic [1:0]  m_prev = 2'b00, m_pend = 2'b00;
  logic [7:0]  m_mem [DEPTH];
  int          m_sp = 0, m_phase = 0, m_src = 0;
  logic [15:0] m_pc = 16'h0000;
  logic [7:0]  m_hi = 8'h00, m_lo = 8'h00;
  logic        m_err = 1'b0;

  int          loads = 0;
  logic [15:0] last_pc = 16'h0000;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic model_step();
    logic [1:0] rise;
    int old_phase;
    int old_sp;
    rise = irq_req & ~m_prev;
    if (!reset) begin
      m_prev = 2'b00; m_pend = 2'b00; m_sp = 0; m_phase = 0;
      m_hi = 8'h00; m_lo = 8'h00; m_err = 1'b0;
      return;
    end
    old_phase = m_phase;
    old_sp    = m_sp;
    m_prev    = irq_req;
    case (old_phase)
      0: if (int_en && m_pend != 2'b00) begin
           if (old_sp <= DEPTH - 2) begin
             m_src = m_pend[0] ? 0 : 1;
             m_pc  = pc_in;
             m_pend[m_src] = 1'b0;
             m_phase = 1;
           end else begin
             m_err = 1'b1;
           end
         end
      1: begin m_mem[old_sp] = m_pc[7:0];  m_sp = old_sp + 1; m_phase = 2; end
      2: begin m_mem[old_sp] = m_pc[15:8]; m_sp = old_sp + 1; m_phase = 3; end
      3: m_phase = 4;
      5: m_phase = 0;
      default: ;
    endcase
    m_pend = m_pend | rise;
    if (old_phase != 1 && old_phase != 2 && (pop_1_stack || pop_2_stack)) begin
      if (old_sp == 0) begin
        m_err = 1'b1;
      end else begin
        m_sp = old_sp - 1;
        if (pop_2_stack) begin
          m_lo = m_mem[m_sp];
          if (old_phase == 4) m_phase = 5;
        end else begin
          m_hi = m_mem[m_sp];
        end
      end
    end
  endtask

  // One clock: advance the model at the edge, compare 1 time unit later.
  task automatic tick();
    logic        e_int, e_load;
    logic [15:0] e_pc;
    @(posedge clock);
    model_step();
    #1;
    e_int  = (m_phase >= 1 && m_phase <= 3);
    e_load = (m_phase == 3 || m_phase == 5);
    e_pc   = (m_phase == 3) ? ((m_src == 1) ? 16'h0013 : 16'h0003) : {m_hi, m_lo};
    expect_eq("int", 32'(intr), 32'(e_int));
    expect_eq("pc_load", 32'(pc_load), 32'(e_load));
    if (e_load) expect_eq("pc_out", 32'(pc_out), 32'(e_pc));
    expect_eq("sp_out", 32'(sp_out), m_sp);
    expect_eq("stack_err", 32'(stack_err), 32'(m_err));
    if (pc_load) begin
      loads++;
      last_pc = pc_out;
      $display("t=%0t pc_load pc_out=%h sp=%0d", $time, pc_out, sp_out);
    end
  endtask

  task automatic pulse0();
    irq_req = 2'b01; tick(); irq_req = 2'b00;
  endtask

  task automatic reti();
    pop_1_stack = 1'b1; tick(); pop_1_stack = 1'b0;
    pop_2_stack = 1'b1; tick(); pop_2_stack = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [1:0] r;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;

    // Reset state
    reset = 1'b0;
    repeat (3) tick();
    expect_eq("rst_sp", 32'(sp_out), 0);
    expect_eq("rst_pc_out", 32'(pc_out), 0);

    // Single entry from irq 0
    reset = 1'b1; int_en = 1'b1; pc_in = 16'h1234;
    loads = 0; cnt = 0;
    pulse0();
    repeat (6) begin tick(); if (intr) cnt++; end
    expect_eq("entry_int_cycles", cnt, 3);
    expect_eq("entry_loads", loads, 1);
    expect_eq("entry_vec", 32'(last_pc), 'h0003);
    expect_eq("entry_sp", 32'(sp_out), 2);
    pc_in = 16'hBEEF;

    // RETI restores the saved PC
    reti();
    expect_eq("reti_sp", 32'(sp_out), 0);
    expect_eq("reti_load", 32'(pc_load), 1);
    expect_eq("reti_pc", 32'(pc_out), 'h1234);
    tick();

    // Simultaneous edges: irq 0 first, then irq 1
    irq_req = 2'b11; tick(); irq_req = 2'b00;
    repeat (5) tick();
    expect_eq("prio_first", 32'(last_pc), 'h0003);
    reti();
    repeat (5) tick();
    expect_eq("prio_second", 32'(last_pc), 'h0013);
    reti();
    tick();

    // Edge held off by int_en
    int_en = 1'b0; cnt = 0;
    pulse0();
    repeat (10) begin tick(); if (intr) cnt++; end
    expect_eq("gated_int", cnt, 0);
    int_en = 1'b1; tick();
    expect_eq("ungated_int", 32'(intr), 1);
    repeat (3) tick();
    reti();
    tick();

    // Reset during PUSH_HI aborts the entry
    pulse0(); tick(); tick();
    reset = 1'b0; tick(); reset = 1'b1;
    expect_eq("abort_int", 32'(intr), 0);
    expect_eq("abort_load", 32'(pc_load), 0);
    expect_eq("abort_sp", 32'(sp_out), 0);

    // Overflow: grow the stack with pop_2-only returns until sp=3
    repeat (3) begin
      pulse0(); repeat (5) tick();
      pop_2_stack = 1'b1; tick(); pop_2_stack = 1'b0; tick();
    end
    expect_eq("ovf_sp_before", 32'(sp_out), 3);
    pulse0(); repeat (4) tick();
    expect_eq("ovf_err", 32'(stack_err), 1);
    expect_eq("ovf_sp", 32'(sp_out), 3);

    // Underflow from an empty stack
    reset = 1'b0; tick(); reset = 1'b1;
    pop_1_stack = 1'b1; tick(); pop_1_stack = 1'b0;
    expect_eq("unf_err", 32'(stack_err), 1);
    expect_eq("unf_sp", 32'(sp_out), 0);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 149) != 0);
      r = irq_req;
      for (int b = 0; b < 2; b++) if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      irq_req = r;
      int_en = ($urandom_range(0, 3) != 0);
      pc_in = 16'($urandom);
      pop_1_stack = 1'b0; pop_2_stack = 1'b0;
      if (m_phase == 4) begin
        case ($urandom_range(0, 9))
          0, 1, 2: pop_1_stack = 1'b1;
          3, 4, 5: pop_2_stack = 1'b1;
          6:       begin pop_1_stack = 1'b1; pop_2_stack = 1'b1; end
          default: ;
        endcase
      end else if (m_phase == 0 && $urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 0) pop_1_stack = 1'b1;
        else pop_2_stack = 1'b1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter STACK_DEPTH, default 16, number of byte entries in the return-address stack (power of two, at least 4).
REQ-002 Parameter VEC0, default 16'h0003, service address for irq_req[0].
REQ-003 Parameter VEC1, default 16'h0013, service address for irq_req[1].
REQ-004 Port: clock  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  in  1  synchronous, active-low reset; reset==0 at a rising edge of clock resets the block.
REQ-006 Port: irq_req  in  2  external interrupt lines, synchronous to clock, rising-edge triggered.
REQ-007 Port: int_en  in  1  control-unit acceptance window (high in its start and halt states).
REQ-008 Port: pc_in  in  16  current program counter, the return address to save.
REQ-009 Port: pop_1_stack  in  1  first RETI pop, which returns the high byte.
REQ-010 Port: pop_2_stack  in  1  second RETI pop, which returns the low byte.
REQ-011 Port: int  out  1  interrupt-in-progress signal to the control unit; holds the control unit's FSM.
REQ-012 Port: pc_load  out  1  one-cycle strobe that loads pc_out into the program counter.
REQ-013 Port: pc_out  out  16  vector or return address; valid when pc_load==1.
REQ-014 Port: sp_out  out  log2(STACK_DEPTH)+1  current stack pointer (byte count).
REQ-015 Port: stack_err  out  1  sticky overflow/underflow flag.

Function
REQ-016 Edge detect: a rising edge is irq_q[i]==0 && irq_req[i]==1 at a clock edge; it sets pending[i]; irq_q is updated every cycle.
REQ-017 pending[i] stays set until serviced; more edges while pending do not count (no queuing).
REQ-018 The FSM states are IDLE, PUSH_LO, PUSH_HI, VECTOR, IN_SERVICE and RETURN.
REQ-019 IDLE -> PUSH_LO when int_en==1, pending!=0 and sp_out<=STACK_DEPTH-2. That same edge latches pc_in, selects the source (irq 0 has priority over irq 1), and clears the selected pending bit.
REQ-020 An edge on the selected line in the same cycle as service start re-sets its pending bit.
REQ-021 Overflow case: sp_out>STACK_DEPTH-2 with a service condition otherwise met. The FSM stays in IDLE, stack_err is set, and pending is unchanged.
REQ-022 PUSH_LO: stack[sp]<=pc[7:0], sp<=sp+1; then go to PUSH_HI.
REQ-023 PUSH_HI: stack[sp]<=pc[15:8], sp<=sp+1; then go to VECTOR.
REQ-024 VECTOR: pc_load=1 and pc_out=VEC0 or VEC1 for the selected source; then go to IN_SERVICE.
REQ-025 int==1 exactly in PUSH_LO, PUSH_HI and VECTOR, i.e. 3 cycles per entry; the output is registered and decoded from state only.
REQ-026 IN_SERVICE: no nesting; new edges only set pending.
REQ-027 IN_SERVICE, pop_1_stack==1: sp<=sp-1 and ret_hi<=stack[sp-1].
REQ-028 IN_SERVICE, pop_2_stack==1: sp<=sp-1, ret_lo<=stack[sp-1]; then go to RETURN.
REQ-029 RETURN: pc_load=1 and pc_out={ret_hi,ret_lo}; then go to IDLE.
REQ-030 Pop order is pop_1 then pop_2 on separate cycles; pop_2 without a prior pop_1 uses the last ret_hi.
REQ-031 A pop with sp_out==0, in any state, sets stack_err and leaves sp unchanged.
REQ-032 Pops outside IN_SERVICE still move sp as in REQ-027/028 but cause no FSM transition.
REQ-033 pop_1_stack and pop_2_stack high together: pop_2 wins and pop_1 is ignored.
REQ-034 Pending edges wait in IDLE until int_en==1; sp never exceeds STACK_DEPTH.

Reset
REQ-035 reset==0 at an edge forces all of the following: state IDLE, sp_out 0, pending 0, irq_q 0, ret_hi/ret_lo 0, int 0, pc_load 0, pc_out 16'h0000, stack_err 0.
REQ-036 Stack contents are not cleared by reset.
REQ-037 Reset mid-entry or mid-return aborts the sequence with no pc_load.
REQ-038 A line already high when reset is released counts as a rising edge.

Verification
REQ-039 pc_in=16'h1234, int_en=1, pulse irq_req[0] -> int high 3 cycles; stack[0]=8'h34, stack[1]=8'h12; one pc_load with pc_out=16'h0003; sp_out=2.
REQ-040 From REQ-039, pop_1 then pop_2 on consecutive cycles -> sp_out 0; next cycle pc_load=1 with pc_out=16'h1234; FSM in IDLE.
REQ-041 Edges on irq_req[1:0] in the same cycle -> VEC0 serviced first; after RETI and int_en=1, VEC1 serviced.
REQ-042 Edge with int_en=0 for 10 cycles -> int stays 0; int rises 1 cycle after int_en goes to 1.
REQ-043 STACK_DEPTH=4, nested state forced with sp_out=3 and a pending edge -> no entry; stack_err=1. Separately, pop at sp_out=0 -> stack_err=1 and sp_out=0.
REQ-044 reset=0 during PUSH_HI -> next cycle int=0, pc_load=0, sp_out=0, state IDLE.
